// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the XNOR-feedback LFSR pattern generator.
// Hunts for NUM_BITS clean bits, then free-runs the sequence and flags every mismatched bit.
module lfsr_checker #(
  parameter int NUM_BITS   = 5,
  parameter int CNT_BITS   = 16,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Clear,
  input  logic                i_Bit_DV,
  input  logic                i_Bit,
  output logic                o_Locked,
  output logic                o_Error,
  output logic                o_Lock_Lost,
  output logic [CNT_BITS-1:0] o_Err_Count
);

  localparam int FILL_W = $clog2(NUM_BITS + 1);
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int ERR_W  = $clog2(ERR_THRESH + 1);

  typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_CHECK = 1'b1} state_t;

  // Bit k of the mask selects tap s[k+1]
  function automatic logic [31:0] tap_mask(input logic [5:0] n);
    logic [31:0] m;
    case (n)
      6'd3:    m = 32'h0000_0006;
      6'd4:    m = 32'h0000_000C;
      6'd5:    m = 32'h0000_0014;
      6'd6:    m = 32'h0000_0030;
      6'd7:    m = 32'h0000_0060;
      6'd8:    m = 32'h0000_00B8;
      6'd9:    m = 32'h0000_0110;
      6'd10:   m = 32'h0000_0240;
      6'd11:   m = 32'h0000_0500;
      6'd12:   m = 32'h0000_0829;
      6'd13:   m = 32'h0000_100D;
      6'd14:   m = 32'h0000_2015;
      6'd15:   m = 32'h0000_6000;
      6'd16:   m = 32'h0000_D008;
      6'd17:   m = 32'h0001_2000;
      6'd18:   m = 32'h0002_0400;
      6'd19:   m = 32'h0004_0023;
      6'd20:   m = 32'h0009_0000;
      6'd21:   m = 32'h0014_0000;
      6'd22:   m = 32'h0030_0000;
      6'd23:   m = 32'h0042_0000;
      6'd24:   m = 32'h00E1_0000;
      6'd25:   m = 32'h0120_0000;
      6'd26:   m = 32'h0200_0023;
      6'd27:   m = 32'h0400_0013;
      6'd28:   m = 32'h0900_0000;
      6'd29:   m = 32'h1400_0000;
      6'd30:   m = 32'h2000_0029;
      6'd31:   m = 32'h4800_0000;
      6'd32:   m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  localparam logic [5:0]          NB6        = NUM_BITS[5:0];
  localparam logic [31:0]         TAP_MASK32 = tap_mask(NB6);
  localparam logic [NUM_BITS-1:0] TAPS       = TAP_MASK32[NUM_BITS-1:0];
  localparam logic [FILL_W-1:0]   FILL_LAST  = FILL_W'(NUM_BITS - 1);
  localparam logic [WIN_W-1:0]    WIN_END    = WIN_W'(WINDOW);
  localparam logic [ERR_W-1:0]    ERR_LIM    = ERR_W'(ERR_THRESH);
  localparam logic [CNT_BITS-1:0] CNT_MAX    = {CNT_BITS{1'b1}};

  // Every tap table entry has an even tap count, so the XNOR chain reduces to an inverted XOR
  function automatic logic feedback(input logic [NUM_BITS-1:0] s);
    return ~^(s & TAPS);
  endfunction

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] s_q, s_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]    win_err_q, win_err_d;
  logic [CNT_BITS-1:0] err_cnt_q, err_cnt_d;
  logic                error_q, error_d;
  logic                lock_lost_q, lock_lost_d;

  logic                pred;
  logic                mismatch;
  logic                cnt_inc;
  logic [NUM_BITS-1:0] hunt_s;
  logic [WIN_W-1:0]    win_cnt_inc;
  logic [ERR_W-1:0]    win_err_inc;

  // Next-state: hunt/check sequencing, window bookkeeping and error counting
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    error_d     = 1'b0;
    lock_lost_d = 1'b0;
    cnt_inc     = 1'b0;
    pred        = feedback(s_q);
    mismatch    = i_Bit ^ pred;
    hunt_s      = {s_q[NUM_BITS-2:0], i_Bit};
    win_cnt_inc = win_cnt_q + 1'b1;
    win_err_inc = win_err_q + ERR_W'(mismatch);

    if (i_Bit_DV) begin
      case (state_q)
        ST_HUNT: begin
          s_d = hunt_s;
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            // All ones is the XNOR lock-up state: keep hunting
            if (&hunt_s) begin
              state_d = ST_HUNT;
            end else begin
              state_d   = ST_CHECK;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        ST_CHECK: begin
          s_d     = {s_q[NUM_BITS-2:0], pred};
          error_d = mismatch;
          cnt_inc = mismatch;
          if (mismatch && (win_err_inc == ERR_LIM)) begin
            state_d     = ST_HUNT;
            lock_lost_d = 1'b1;
            fill_d      = '0;
            s_d         = s_q;
          end else if (win_cnt_inc == WIN_END) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_inc;
            win_err_d = win_err_inc;
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (i_Clear) begin
      err_cnt_d = '0;
    end else if (cnt_inc && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_HUNT;
      s_q         <= '0;
      fill_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      error_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      error_q     <= error_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign o_Locked    = (state_q == ST_CHECK);
  assign o_Error     = error_q;
  assign o_Lock_Lost = lock_lost_q;
  assign o_Err_Count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single errors, lock loss, lock-up stream,
// saturation with clear, asynchronous reset and DV gaps.
module tb_lfsr_checker;

  logic        i_Clk    = 1'b0;
  logic        i_Rst_L  = 1'b0;
  logic        i_Clear  = 1'b0;
  logic        i_Bit_DV = 1'b0;
  logic        i_Bit    = 1'b0;
  logic        o_Locked, o_Error, o_Lock_Lost;
  logic [15:0] o_Err_Count;
  logic        locked4, error4, lost4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;
  logic [4:0] g;  // generator state, g[0] = newest bit

  always #5 i_Clk = ~i_Clk;

  lfsr_checker #(.NUM_BITS(5), .CNT_BITS(16), .WINDOW(64), .ERR_THRESH(4)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Clear(i_Clear), .i_Bit_DV(i_Bit_DV), .i_Bit(i_Bit),
    .o_Locked(o_Locked), .o_Error(o_Error), .o_Lock_Lost(o_Lock_Lost), .o_Err_Count(o_Err_Count)
  );

  lfsr_checker #(.NUM_BITS(5), .CNT_BITS(4), .WINDOW(64), .ERR_THRESH(4)) dut4 (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Clear(i_Clear), .i_Bit_DV(i_Bit_DV), .i_Bit(i_Bit),
    .o_Locked(locked4), .o_Error(error4), .o_Lock_Lost(lost4), .o_Err_Count(cnt4)
  );

  // Team generator: XNOR of taps 5 and 3, newest bit shifted into the LSB
  task automatic gen_next(output logic b);
    b = ~(g[4] ^ g[2]);
    g = {g[3:0], b};
  endtask

  task automatic step(input logic dv, input logic b, input logic clr);
    @(negedge i_Clk);
    i_Bit_DV = dv;
    i_Bit    = b;
    i_Clear  = clr;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Rst_L  = 1'b0;
    i_Bit_DV = 1'b0;
    i_Clear  = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    g = 5'd0;
  endtask

  task automatic test_reset();
    @(negedge i_Clk);
    @(negedge i_Clk);
    checks++; if (o_Locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", o_Locked); end
    checks++; if (o_Error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", o_Error); end
    checks++; if (o_Lock_Lost !== 1'b0) begin errors++; $display("FAIL reset_lost got=%b exp=0", o_Lock_Lost); end
    checks++; if (o_Err_Count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_Err_Count); end
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL reset_count4 got=%0d exp=0", cnt4); end
    i_Rst_L = 1'b1;
    g = 5'd0;
  endtask

  task automatic test_lock();
    logic b;
    logic exp_lock;
    for (int k = 1; k <= 100; k++) begin
      gen_next(b);
      step(1'b1, b, 1'b0);
      exp_lock = (k >= 5);
      checks++; if (o_Locked !== exp_lock) begin errors++; $display("FAIL lock_locked k=%0d got=%b exp=%b", k, o_Locked, exp_lock); end
      checks++; if (o_Error !== 1'b0) begin errors++; $display("FAIL lock_error k=%0d got=%b exp=0", k, o_Error); end
    end
    checks++; if (o_Err_Count !== 16'd0) begin errors++; $display("FAIL lock_count got=%0d exp=0", o_Err_Count); end
  endtask

  task automatic test_single_error();
    logic b;
    logic flip;
    for (int i = 1; i <= 40; i++) begin
      gen_next(b);
      flip = (i == 20);
      step(1'b1, b ^ flip, 1'b0);
      checks++; if (o_Error !== flip) begin errors++; $display("FAIL single_error i=%0d got=%b exp=%b", i, o_Error, flip); end
      checks++; if (o_Locked !== 1'b1) begin errors++; $display("FAIL single_locked i=%0d got=%b exp=1", i, o_Locked); end
    end
    checks++; if (o_Err_Count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", o_Err_Count); end
  endtask

  task automatic test_lock_loss();
    logic b;
    logic flip;
    logic exp_lock;
    step(1'b0, 1'b0, 1'b1);
    checks++; if (o_Err_Count !== 16'd0) begin errors++; $display("FAIL loss_clear got=%0d exp=0", o_Err_Count); end
    for (int i = 1; i <= 20; i++) begin
      gen_next(b);
      flip = (i == 2) || (i == 4) || (i == 6) || (i == 8);
      step(1'b1, b ^ flip, 1'b0);
      exp_lock = (i < 8) || (i >= 13);
      checks++; if (o_Error !== flip) begin errors++; $display("FAIL loss_error i=%0d got=%b exp=%b", i, o_Error, flip); end
      checks++; if (o_Lock_Lost !== (i == 8)) begin errors++; $display("FAIL loss_pulse i=%0d got=%b exp=%b", i, o_Lock_Lost, (i == 8)); end
      checks++; if (o_Locked !== exp_lock) begin errors++; $display("FAIL loss_locked i=%0d got=%b exp=%b", i, o_Locked, exp_lock); end
    end
    checks++; if (o_Err_Count !== 16'd4) begin errors++; $display("FAIL loss_count got=%0d exp=4", o_Err_Count); end
  endtask

  task automatic test_no_lock_ones();
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++; if (o_Locked !== 1'b0) begin errors++; $display("FAIL ones_locked k=%0d got=%b exp=0", k, o_Locked); end
    end
    checks++; if (o_Err_Count !== 16'd0) begin errors++; $display("FAIL ones_count got=%0d exp=0", o_Err_Count); end
  endtask

  task automatic test_saturate_clear();
    logic b;
    logic [3:0] exp4;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      gen_next(b);
      step(1'b1, b, 1'b0);
    end
    checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_lock got=%b exp=1", locked4); end
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < 64; i++) begin
        gen_next(b);
        step(1'b1, b ^ (i == 10), 1'b0);
      end
      exp4 = (w + 1 > 15) ? 4'd15 : 4'(w + 1);
      checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_locked w=%0d got=%b exp=1", w, locked4); end
      checks++; if (cnt4 !== exp4) begin errors++; $display("FAIL sat_count4 w=%0d got=%0d exp=%0d", w, cnt4, exp4); end
      checks++; if (o_Err_Count !== 16'(w + 1)) begin errors++; $display("FAIL sat_count16 w=%0d got=%0d exp=%0d", w, o_Err_Count, w + 1); end
    end
    gen_next(b);
    step(1'b1, ~b, 1'b1);
    checks++; if (error4 !== 1'b1) begin errors++; $display("FAIL clr_err_pulse got=%b exp=1", error4); end
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL clr_count4 got=%0d exp=0", cnt4); end
    checks++; if (o_Err_Count !== 16'd0) begin errors++; $display("FAIL clr_count16 got=%0d exp=0", o_Err_Count); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL clr_hold got=%0d exp=0", cnt4); end
  endtask

  task automatic test_async_reset_gaps();
    logic b;
    logic junk;
    logic exp_lock;
    int   valid;
    gen_next(b);
    step(1'b1, ~b, 1'b0);
    checks++; if (o_Error !== 1'b1) begin errors++; $display("FAIL ar_pre_error got=%b exp=1", o_Error); end
    checks++; if (o_Err_Count !== 16'd1) begin errors++; $display("FAIL ar_pre_count got=%0d exp=1", o_Err_Count); end
    #2;
    i_Rst_L  = 1'b0;
    i_Bit_DV = 1'b0;
    #1;
    checks++; if (o_Locked !== 1'b0) begin errors++; $display("FAIL ar_locked got=%b exp=0", o_Locked); end
    checks++; if (o_Error !== 1'b0) begin errors++; $display("FAIL ar_error got=%b exp=0", o_Error); end
    checks++; if (o_Err_Count !== 16'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", o_Err_Count); end
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    g = 5'd0;
    valid = 0;
    for (int k = 1; k <= 30; k++) begin
      junk = 1'($urandom_range(0, 1));
      step(1'b0, junk, 1'b0);
      exp_lock = (valid >= 5);
      checks++; if (o_Locked !== exp_lock) begin errors++; $display("FAIL gap_hold k=%0d got=%b exp=%b", k, o_Locked, exp_lock); end
      checks++; if (o_Error !== 1'b0) begin errors++; $display("FAIL gap_error k=%0d got=%b exp=0", k, o_Error); end
      gen_next(b);
      step(1'b1, b, 1'b0);
      valid++;
      exp_lock = (valid >= 5);
      checks++; if (o_Locked !== exp_lock) begin errors++; $display("FAIL gap_locked k=%0d got=%b exp=%b", k, o_Locked, exp_lock); end
      checks++; if (o_Error !== 1'b0) begin errors++; $display("FAIL gap_valid_error k=%0d got=%b exp=0", k, o_Error); end
    end
    checks++; if (o_Err_Count !== 16'd0) begin errors++; $display("FAIL gap_count got=%0d exp=0", o_Err_Count); end
  endtask

  initial begin
    g = 5'd0;
    test_reset();
    test_lock();
    test_single_error();
    test_lock_loss();
    test_no_lock_ones();
    test_saturate_clear();
    test_async_reset_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
